// File: rtl/fetch_stage.sv
// Instruction fetch stage: sequential PC, stall-tolerant memory handshake, branch redirect.
// Optional wait-cycle counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic        valid,
    output logic [31:0] stall_count
);

    localparam logic [1:0] StFetch = 2'd0;
    localparam logic [1:0] StHold  = 2'd1;
    localparam logic [1:0] StDrop  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] pc_inc;

    assign pc_inc    = pc_q + 32'd4;
    assign imem_req  = (state_q != StHold);
    // In DROP the abandoned request must keep its address until the memory acks it.
    assign imem_addr = (state_q == StDrop) ? drop_addr_q : pc_q;

    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign valid       = valid_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        instr_d     = instr_q;
        pc_out_d    = pc_out_q;
        valid_d     = valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;

        if (branch_taken) begin
            pc_d        = branch_addr;
            valid_d     = 1'b0;
            instr_d     = 32'd0;
            buf_instr_d = 32'd0;
            buf_pc_d    = 32'd0;
            case (state_q)
                StFetch: begin
                    if (!imem_ack) begin
                        state_d     = StDrop;
                        drop_addr_d = pc_q;
                    end
                end
                StHold:  state_d = StFetch;
                StDrop:  if (imem_ack) state_d = StFetch;
                default: state_d = StFetch;
            endcase
        end else begin
            case (state_q)
                StFetch: begin
                    if (imem_ack) begin
                        pc_d = pc_inc;
                        if (freeze) begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = pc_inc;
                            state_d     = StHold;
                        end else begin
                            instr_d  = imem_rdata;
                            pc_out_d = pc_inc;
                            valid_d  = 1'b1;
                        end
                    end else if (!freeze) begin
                        instr_d = 32'd0;
                        valid_d = 1'b0;
                    end
                end
                StHold: begin
                    if (!freeze) begin
                        instr_d  = buf_instr_q;
                        pc_out_d = buf_pc_q;
                        valid_d  = 1'b1;
                        state_d  = StFetch;
                    end
                end
                StDrop: begin
                    if (imem_ack) state_d = StFetch;
                    if (!freeze) begin
                        instr_d = 32'd0;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            drop_addr_q <= 32'd0;
            instr_q     <= 32'd0;
            pc_out_q    <= 32'd0;
            valid_q     <= 1'b0;
            buf_instr_q <= 32'd0;
            buf_pc_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
            valid_q     <= valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= 32'd0;
        end else if (imem_req && !imem_ack && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: sequential fetch, wait states, freeze/HOLD,
// branch redirect through DROP, wrap-around and reset mid-transaction.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        valid;
    logic [31:0] stall_count;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] WBase = 32'hE3A0_1001;
`ifdef FETCH_STALL_CNT_EN
    localparam logic [31:0] CntEn = 32'd1;
`else
    localparam logic [31:0] CntEn = 32'd0;
`endif

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .pc_out       (pc_out),
        .valid        (valid),
        .stall_count  (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One acked fetch with freeze low: word must appear on the very next cycle.
    task automatic fetch_ok(input logic [31:0] addr, input logic [31:0] word);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        chk("fetch_valid", {31'd0, valid}, 32'd1);
        chk("fetch_instr", instruction, word);
        chk("fetch_pc_out", pc_out, addr + 32'd4);
    endtask

    initial begin
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'd0;

        // Reset state
        step();
        step();
        chk("rst_instr", instruction, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_stall", stall_count, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        chk("rel_req", {31'd0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'd0);

        // Back-to-back acks from address 0
        for (int i = 0; i < 4; i++) begin
            fetch_ok(32'(i * 4), WBase + 32'(i));
        end

        // Three wait cycles at 0x10
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wait_addr", imem_addr, 32'h10);
            chk("wait_valid", {31'd0, valid}, 32'd0);
            chk("wait_instr", instruction, 32'd0);
            chk("wait_pc_out", pc_out, 32'h10);
        end
        chk("wait_stall", stall_count, 32'd3 * CntEn);
        fetch_ok(32'h10, 32'h1111_0010);
        fetch_ok(32'h14, 32'h1111_0014);
        fetch_ok(32'h18, 32'h1111_0018);
        fetch_ok(32'h1C, 32'h1111_001C);

        // Freeze while 0x20 is acked, held four cycles
        freeze     = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h2222_0020;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            chk("frz_req", {31'd0, imem_req}, 32'd0);
            chk("frz_instr", instruction, 32'h1111_001C);
            chk("frz_pc_out", pc_out, 32'h20);
            chk("frz_valid", {31'd0, valid}, 32'd1);
            if (i < 3) step();
        end
        freeze = 1'b0;
        step();
        chk("unfrz_instr", instruction, 32'h2222_0020);
        chk("unfrz_pc_out", pc_out, 32'h24);
        chk("unfrz_valid", {31'd0, valid}, 32'd1);
        chk("unfrz_addr", imem_addr, 32'h24);
        chk("unfrz_req", {31'd0, imem_req}, 32'd1);
        chk("frz_stall", stall_count, 32'd3 * CntEn);

        for (int a = 32'h24; a <= 32'h3C; a += 4) begin
            fetch_ok(32'(a), 32'h3333_0000 + 32'(a));
        end

        // Branch to 0x100 while 0x40 is pending
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        step();
        branch_taken = 1'b0;
        chk("drop_addr0", imem_addr, 32'h40);
        chk("drop_req0", {31'd0, imem_req}, 32'd1);
        chk("drop_valid0", {31'd0, valid}, 32'd0);
        chk("drop_instr0", instruction, 32'd0);
        step();
        chk("drop_addr1", imem_addr, 32'h40);
        chk("drop_valid1", {31'd0, valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0040;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        chk("drop_done_addr", imem_addr, 32'h100);
        chk("drop_done_valid", {31'd0, valid}, 32'd0);
        chk("drop_done_instr", instruction, 32'd0);
        step();
        chk("tgt_wait_valid", {31'd0, valid}, 32'd0);
        chk("drop_stall", stall_count, 32'd6 * CntEn);
        fetch_ok(32'h100, 32'h4444_0100);

        // Branch together with freeze and an ack
        freeze       = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h200;
        imem_ack     = 1'b1;
        imem_rdata   = 32'hDEAD_0104;
        step();
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'd0;
        freeze       = 1'b0;
        chk("bfrz_valid", {31'd0, valid}, 32'd0);
        chk("bfrz_instr", instruction, 32'd0);
        chk("bfrz_addr", imem_addr, 32'h200);
        chk("bfrz_req", {31'd0, imem_req}, 32'd1);

        // Branch out of HOLD discards the buffered word
        freeze     = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0200;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        freeze       = 1'b0;
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk("bhold_valid", {31'd0, valid}, 32'd0);
        chk("bhold_instr", instruction, 32'd0);

        // PC wrap-around
        fetch_ok(32'hFFFF_FFFC, 32'h5555_FFFC);
        chk("wrap_addr", imem_addr, 32'd0);
        fetch_ok(32'h0, 32'h6666_0000);

        // Reset asserted mid-DROP, with a late ack around it
        branch_taken = 1'b1;
        branch_addr  = 32'h500;
        step();
        branch_taken = 1'b0;
        chk("pre_rst_addr", imem_addr, 32'h4);
        #3;
        rst = 1'b0;
        #1;
        chk("mrst_instr", instruction, 32'd0);
        chk("mrst_pc_out", pc_out, 32'd0);
        chk("mrst_valid", {31'd0, valid}, 32'd0);
        chk("mrst_stall", stall_count, 32'd0);
        chk("mrst_addr", imem_addr, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_0004;
        step();
        @(negedge clk);
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        chk("mrel_addr", imem_addr, 32'd0);
        chk("mrel_req", {31'd0, imem_req}, 32'd1);
        step();
        chk("mrel_valid", {31'd0, valid}, 32'd0);
        chk("mrel_instr", instruction, 32'd0);
        fetch_ok(32'h0, WBase);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 freeze  input  1  hazard stall from decode; hold the output register.
REQ-005 branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-006 branch_addr  input  32  redirect target, valid with branch_taken.
REQ-007 imem_req  output  1  instruction memory request, level-held until imem_ack.
REQ-008 imem_addr  output  32  fetch address; stable while imem_req=1 and no ack.
REQ-009 imem_ack  input  1  completion strobe; meaningful only while imem_req=1.
REQ-010 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-011 instruction  output  32  registered instruction to decode.
REQ-012 pc_out  output  32  registered fetch address + 4 of that instruction.
REQ-013 valid  output  1  instruction/pc_out hold a real instruction.
REQ-014 stall_count  output  32  wait-cycle counter (see Configuration).

Function
REQ-015 States: FETCH (imem_req=1, imem_addr=PC), HOLD (imem_req=0, fetched word buffered), DROP (imem_req=1, imem_addr=stale address, response discarded).
REQ-016 FETCH, imem_ack=1, freeze=0, no branch: instruction<=imem_rdata, pc_out<=PC+4, valid<=1, PC<=PC+4, stay FETCH; back-to-back acks give one instruction per cycle.
REQ-017 FETCH, imem_ack=1, freeze=1, no branch: buffer word and PC+4, PC<=PC+4, go HOLD; output register unchanged.
REQ-018 HOLD, freeze=0, no branch: load output from buffer, valid<=1, go FETCH.
REQ-019 Any state, freeze=1: instruction, pc_out, valid hold their values (unless branch).
REQ-020 Any state, freeze=0 and no word delivered this cycle: valid<=0, instruction<=0, pc_out unchanged (bubble).
REQ-021 branch_taken has priority over freeze and ack: PC<=branch_addr, valid<=0, instruction<=0, buffer discarded.
REQ-022 branch_taken in FETCH without ack: go DROP (old address held until ack, protocol preserved); ack in DROP discarded, go FETCH at new PC.
REQ-023 branch_taken in FETCH with ack same cycle, or in HOLD: data discarded, go FETCH at branch_addr next cycle.
REQ-024 branch_taken in DROP: PC<=branch_addr (latest target wins), stay DROP until ack.
REQ-025 Latency: word acked in cycle N is visible on instruction in cycle N+1 when freeze=0.
REQ-026 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

Reset
REQ-027 rst=0 asynchronously forces: state FETCH, PC=RESET_PC, instruction=0, pc_out=0, valid=0, buffer cleared, stall_count=0.
REQ-028 imem_req=1 with imem_addr=RESET_PC in the first cycle after rst deasserts.
REQ-029 Reset mid-transaction abandons the outstanding request; a late ack is never delivered to decode.

Configuration
REQ-030 Macro FETCH_STALL_CNT_EN defined: stall_count increments (saturating at 32'hFFFF_FFFF) each cycle imem_req=1 and imem_ack=0.
REQ-031 Macro FETCH_STALL_CNT_EN undefined: no counter logic; stall_count tied to 0; all other behaviour identical.

Verification
REQ-032 Reset release, RESET_PC=0, ack every cycle, words 0xE3A0_1001.. -> imem_addr 0,4,8,...; valid=1 from cycle 2; pc_out 4,8,12,...
REQ-033 Ack delayed 3 cycles at addr 0x10 -> imem_addr stays 0x10, valid=0 for 3 cycles; with macro, stall_count=3.
REQ-034 freeze=1 when ack at 0x20 arrives, held 4 cycles -> output holds previous word, HOLD entered, imem_req=0; freeze=0 -> word of 0x20 delivered next cycle, fetch resumes at 0x24.
REQ-035 branch_taken to 0x100 while ack at 0x40 pending -> imem_addr stays 0x40 until ack, that word discarded, next request 0x100, valid=0 until 0x100 word arrives.
REQ-036 branch_taken together with freeze=1 -> valid=0 next cycle and fetch at branch_addr; rst=0 mid-DROP -> all outputs 0, imem_addr=RESET_PC after release.
